// File: rtl/goofy_mem_arbiter.sv
// Round-robin two-port arbiter and access sequencer in front of the single-port GoofyRam.
// Each req/ack transaction takes IDLE -> MEM -> DONE, and the ack comes three cycles after the grant.
//
// state | meaning
// IDLE  | waiting for an eligible request; arbitrate and latch the access
// MEM   | latched address/data presented to the RAM, write strobe if write
// DONE  | RAM read data available; capture into grantee rdata, ack next cycle
module goofy_mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_in,
    output logic          ram_save,
    input  logic [DW-1:0] ram_out,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          last_b_q, last_b_d;
    logic          gnt_b_q, gnt_b_d;
    logic          we_q, we_d;
    logic          save_q, save_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          a_ack_q, a_ack_d;
    logic          b_ack_q, b_ack_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;

    logic a_elig, b_elig, pick_b;

    // A port is not eligible in its own ack cycle, which blocks back-to-back regrants.
    assign a_elig = a_req & ~a_ack_q;
    assign b_elig = b_req & ~b_ack_q;
    assign pick_b = b_elig & (~a_elig | ~last_b_q);

    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        gnt_b_d   = gnt_b_q;
        we_d      = we_q;
        save_d    = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (a_elig | b_elig) begin
                    gnt_b_d  = pick_b;
                    last_b_d = pick_b;
                    addr_d   = pick_b ? b_addr  : a_addr;
                    wdata_d  = pick_b ? b_wdata : a_wdata;
                    we_d     = pick_b ? b_we    : a_we;
                    save_d   = pick_b ? b_we    : a_we;
                    state_d  = ST_MEM;
                end
            end
            ST_MEM: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!we_q) begin
                    if (gnt_b_q) b_rdata_d = ram_out;
                    else         a_rdata_d = ram_out;
                end
                a_ack_d = ~gnt_b_q;
                b_ack_d = gnt_b_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= ST_IDLE;
            last_b_q  <= 1'b1;
            gnt_b_q   <= 1'b0;
            we_q      <= 1'b0;
            save_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            gnt_b_q   <= gnt_b_d;
            we_q      <= we_d;
            save_q    <= save_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Gating with res keeps a write from landing in the same cycle a reset aborts it.
    assign ram_save = save_q & ~res;
    assign ram_addr = addr_q;
    assign ram_in   = wdata_q;
    assign busy     = (state_q != ST_IDLE);
    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_goofy_mem_arbiter.sv
// Self-checking bench for goofy_mem_arbiter: directed scenarios plus random two-port traffic,
// all scored against a transaction-level arbitration model and a reference memory image.
module tb_goofy_mem_arbiter;

    logic        clk = 1'b0;
    logic        res;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, b_addr, ram_addr;
    logic [7:0]  a_wdata, b_wdata, a_rdata, b_rdata, ram_in, ram_out;
    logic        a_ack, b_ack, ram_save, busy;

    always #5 clk = ~clk;

    goofy_mem_arbiter #(.AW(16), .DW(8)) dut (
        .clk(clk), .res(res),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_in(ram_in), .ram_save(ram_save),
        .ram_out(ram_out), .busy(busy)
    );

    function automatic logic [7:0] init_val(input int i);
        return i[7:0] ^ 8'h5C;
    endfunction

    // GoofyRam stand-in: registered read, write on ram_save.
    logic [7:0] mem [65536];
    initial begin
        logic [7:0] rd;
        for (int i = 0; i < 65536; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            rd = mem[ram_addr];
            if (ram_save) mem[ram_addr] = ram_in;
            ram_out <= rd;
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // requester agents
    bit          pend [2];
    bit          held [2];
    bit          granted [2];
    bit          cur_we [2];
    logic [15:0] cur_addr [2];
    logic [7:0]  cur_wd [2];
    bit          auto_mode = 0;
    bit          res_cmd = 1;

    // reference model
    bit          m_active = 0;
    int          m_g = 0;
    int          m_port = 0;
    bit          m_we = 0;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wd = '0;
    bit          m_last_b = 1;
    logic [7:0]  exp_rd [2];
    logic [7:0]  ref_mem [65536];

    int ack_cyc [$];
    int ack_port [$];

    task automatic new_txn(input int p, input bit we, input logic [15:0] ad, input logic [7:0] wd);
        pend[p]     = 1;
        granted[p]  = 0;
        cur_we[p]   = we;
        cur_addr[p] = ad;
        cur_wd[p]   = wd;
    endtask

    task automatic rand_txn(input int p);
        logic [15:0] ad;
        case ($urandom_range(0, 3))
            0:       ad = 16'hFFFF;
            1:       ad = 16'($urandom_range(0, 65535));
            default: ad = 16'($urandom_range(0, 7));
        endcase
        new_txn(p, 1'($urandom_range(0, 1)), ad, 8'($urandom_range(0, 255)));
        held[p] = ($urandom_range(0, 3) == 0);
    endtask

    task automatic step();
        bit          drv_req [2];
        bit          drv_we [2];
        logic [15:0] drv_addr [2];
        logic [7:0]  drv_wd [2];
        bit          drv_res;
        bit          e_ack [2];
        bit          elig [2];
        bit          e_busy, e_save, mem_cyc;
        int          pick;

        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < 2; p++) begin
            drv_req[p]  = pend[p];
            drv_we[p]   = cur_we[p];
            drv_addr[p] = cur_addr[p];
            drv_wd[p]   = cur_wd[p];
        end
        drv_res = res_cmd;
        res     = drv_res;
        a_req = drv_req[0]; a_we = drv_we[0]; a_addr = drv_addr[0]; a_wdata = drv_wd[0];
        b_req = drv_req[1]; b_we = drv_we[1]; b_addr = drv_addr[1]; b_wdata = drv_wd[1];

        @(negedge clk);
        mem_cyc = m_active && (cyc == m_g + 1);
        e_busy  = m_active && (cyc == m_g + 1 || cyc == m_g + 2);
        e_save  = mem_cyc && m_we && !drv_res;
        for (int p = 0; p < 2; p++) begin
            e_ack[p] = m_active && (cyc == m_g + 3) && (m_port == p);
            if (e_ack[p] && !m_we) exp_rd[p] = ref_mem[m_addr];
        end
        check_val("a_ack", 32'(a_ack), 32'(e_ack[0]));
        check_val("b_ack", 32'(b_ack), 32'(e_ack[1]));
        check_val("busy", 32'(busy), 32'(e_busy));
        check_val("ram_save", 32'(ram_save), 32'(e_save));
        check_val("a_rdata", 32'(a_rdata), 32'(exp_rd[0]));
        check_val("b_rdata", 32'(b_rdata), 32'(exp_rd[1]));
        if (mem_cyc) begin
            check_val("ram_addr", 32'(ram_addr), 32'(m_addr));
            if (m_we) check_val("ram_in", 32'(ram_in), 32'(m_wd));
        end
        if (a_ack) begin ack_cyc.push_back(cyc); ack_port.push_back(0); end
        if (b_ack) begin ack_cyc.push_back(cyc); ack_port.push_back(1); end

        if (e_save) ref_mem[m_addr] = m_wd;
        for (int p = 0; p < 2; p++)
            if (e_ack[p]) begin
                pend[p]    = held[p];
                granted[p] = 0;
            end
        if (m_active && cyc == m_g + 3) m_active = 0;

        if (drv_res) begin
            m_active = 0;
            m_last_b = 1;
            for (int p = 0; p < 2; p++) begin
                exp_rd[p]  = '0;
                pend[p]    = 0;
                granted[p] = 0;
            end
        end else if (!m_active) begin
            for (int p = 0; p < 2; p++) elig[p] = drv_req[p] && !e_ack[p];
            if (elig[0] || elig[1]) begin
                pick       = (elig[1] && (!elig[0] || !m_last_b)) ? 1 : 0;
                m_active   = 1;
                m_g        = cyc;
                m_port     = pick;
                m_we       = drv_we[pick];
                m_addr     = drv_addr[pick];
                m_wd       = drv_wd[pick];
                m_last_b   = (pick == 1);
                granted[pick] = 1;
            end
        end

        if (auto_mode) begin
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && granted[p] && $urandom_range(0, 1) == 1) begin
                    cur_addr[p] = 16'($urandom_range(0, 65535));
                    cur_wd[p]   = 8'($urandom_range(0, 255));
                    cur_we[p]   = 1'($urandom_range(0, 1));
                end
                if (!pend[p] && $urandom_range(0, 2) == 0) rand_txn(p);
            end
            res_cmd = ($urandom_range(0, 59) == 0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_acks(input int n, input int limit);
        int k = 0;
        while (ack_port.size() < n && k < limit) begin
            step();
            k++;
        end
        check_val("ack_count", 32'(ack_port.size()), 32'(n));
    endtask

    task automatic clear_log();
        ack_cyc.delete();
        ack_port.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
        for (int p = 0; p < 2; p++) begin
            exp_rd[p] = '0; pend[p] = 0; held[p] = 0; granted[p] = 0;
            cur_we[p] = 0; cur_addr[p] = '0; cur_wd[p] = '0;
        end
        res = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;

        // reset defaults
        res_cmd = 1;
        run(2);
        res_cmd = 0;
        step();
        check_val("rst_ram_addr", 32'(ram_addr), 32'h0);
        check_val("rst_ram_in", 32'(ram_in), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);

        // single write then read on A
        clear_log();
        new_txn(0, 1, 16'h1234, 8'h5A);
        t0 = cyc + 1;
        wait_acks(1, 20);
        if (ack_cyc.size() > 0) check_val("wr_latency", 32'(ack_cyc[0] - t0), 32'd3);
        clear_log();
        new_txn(0, 0, 16'h1234, 8'h00);
        t0 = cyc + 1;
        wait_acks(1, 20);
        if (ack_cyc.size() > 0) check_val("rd_latency", 32'(ack_cyc[0] - t0), 32'd3);
        check_val("rd_data", 32'(a_rdata), 32'h5A);

        // simultaneous requests right after reset
        res_cmd = 1;
        step();
        res_cmd = 0;
        step();
        clear_log();
        new_txn(0, 0, 16'h0010, 8'h00);
        new_txn(1, 0, 16'h0020, 8'h00);
        t0 = cyc + 1;
        wait_acks(2, 30);
        if (ack_port.size() >= 2) begin
            check_val("tie_first", 32'(ack_port[0]), 32'd0);
            check_val("tie_first_cyc", 32'(ack_cyc[0] - t0), 32'd3);
            check_val("tie_second", 32'(ack_port[1]), 32'd1);
            check_val("tie_second_cyc", 32'(ack_cyc[1] - t0), 32'd6);
        end
        run(8);
        check_val("tie_no_dup", 32'(ack_port.size()), 32'd2);

        // fairness with both requests held
        clear_log();
        held[0] = 1; held[1] = 1;
        new_txn(0, 0, 16'h0003, 8'h00);
        new_txn(1, 1, 16'h0004, 8'h77);
        wait_acks(6, 60);
        held[0] = 0; held[1] = 0;
        for (int i = 0; i < 6 && i < ack_port.size(); i++) begin
            check_val("rr_order", 32'(ack_port[i]), 32'(i % 2));
            if (i > 0) check_val("rr_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        end
        run(10);

        // reset in the MEM cycle of a B write
        new_txn(1, 1, 16'h0001, 8'hFF);
        step();
        res_cmd = 1;
        step();
        check_val("rst_mem_save", 32'(ram_save), 32'h0);
        res_cmd = 0;
        clear_log();
        run(6);
        check_val("rst_no_ack", 32'(ack_port.size()), 32'd0);
        new_txn(1, 0, 16'h0001, 8'h00);
        wait_acks(1, 20);
        check_val("rst_old_value", 32'(b_rdata), 32'(init_val(1)));

        // held request on A alone: period 4
        clear_log();
        held[0] = 1;
        new_txn(0, 0, 16'h0040, 8'h00);
        t0 = cyc + 1;
        wait_acks(3, 40);
        held[0] = 0;
        if (ack_cyc.size() >= 3) begin
            check_val("hold_first", 32'(ack_cyc[0] - t0), 32'd3);
            check_val("hold_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd4);
            check_val("hold_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd4);
        end
        run(10);

        // random traffic with occasional resets
        auto_mode = 1;
        run(3000);
        auto_mode = 0;
        res_cmd = 0;
        held[0] = 0; held[1] = 0;
        run(20);
        check_val("drained_busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/goofy_mem_arbiter.md
# goofy_mem_arbiter

Two-port arbiter and access sequencer in front of the single-port `GoofyRam`. It shares the RAM between port A (the core's fetch/data access path) and port B (a loader/DMA or I/O agent). Each access is a simple req/ack transaction, and the RAM's one-cycle registered read is hidden behind the handshake. Ties are resolved round-robin so neither port can starve the other.

## Interface
Parameters:
- `AW`, 16, address width (matches RAM address).
- `DW`, 8, data width (matches RAM word).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `res`  in  1  reset, synchronous, active-high.
- `a_req`  in  1  port A request; held until `a_ack`.
- `a_we`  in  1  port A write enable (1 = write, 0 = read).
- `a_addr`  in  AW  port A address.
- `a_wdata`  in  DW  port A write data.
- `a_ack`  out  1  one-cycle completion pulse for port A.
- `a_rdata`  out  DW  port A read data; valid while `a_ack` = 1.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: same as port A, for port B.
- `ram_addr`  out  AW  RAM address.
- `ram_in`  out  DW  RAM write data.
- `ram_save`  out  1  RAM write strobe.
- `ram_out`  in  DW  RAM read data, valid one edge after `ram_addr` is presented.
- `busy`  out  1  high when state ≠ IDLE.

## Operation
- FSM states: IDLE, MEM, DONE.
- **IDLE**
  - A port is eligible if its `req` = 1 and its `ack` is not high in this cycle.
  - Exactly one eligible port: grant it.
  - Both eligible: grant the port not granted last (`last_b` pointer).
  - On a grant, latch `addr`/`we`/`wdata` and the grantee id, set `last_b` = (grantee == B), and go to MEM.
  - No eligible port: stay in IDLE.
- **MEM**
  - `ram_addr`/`ram_in` driven from the latched registers.
  - `ram_save` = latched `we`.
  - Next state DONE.
- **DONE**
  - Register `ram_out` into the grantee's `rdata`. For writes the value is don't-care; the bench checks `rdata` on reads only.
  - Set the grantee's `ack` for the next cycle and return to IDLE.
- Request inputs are sampled only in IDLE. Changes to `addr`/`we`/`wdata` after the grant are ignored.
- `ram_save` = `save_q & ~res`, so no RAM write occurs in any cycle where `res` is high.
- `rdata` registers hold their value until that port's next completed read.
- Reset values:
  - state = IDLE, `last_b` = 1 (so A wins the first tie).
  - `a_ack` = `b_ack` = 0, `a_rdata` = `b_rdata` = 0.
  - `ram_addr` = 0, `ram_in` = 0, `ram_save` = 0, `busy` = 0.
- Reset mid-transaction (MEM or DONE):
  - Transaction is abandoned and no `ack` is issued.
  - A write in MEM is suppressed whenever `res` is high in that cycle.
  - The requester must reissue after reset.

## Timing
- Cycle 0 (IDLE, `req` seen) → cycle 1 MEM → cycle 2 DONE → cycle 3 `ack` high, FSM in IDLE.
- Latency is 3 cycles from the request-sampled cycle to `ack`.
- Throughput:
  - Same port with `req` held continuously: it is ineligible in its `ack` cycle, so its next grant is in cycle 4. Period is 4 cycles.
  - Other port pending at `ack`: it is granted in the `ack` cycle. Period is 3 cycles.
- Round-robin with both ports held continuously gives A, B, A, B….
- `busy` is high in the MEM and DONE cycles only.
- `a_ack` and `b_ack` are never high in the same cycle.
- Address wrap: full AW range is passed through unmodified. No arithmetic in the block.

## Test plan
- **Reset defaults.** Assert `res` for 2 cycles, then release → all outputs at their reset values; `busy` = 0.
- **Single write then read on A.** `a_req`=1, `a_we`=1, `a_addr`=0x1234, `a_wdata`=0x5A → `ram_save`=1 with `ram_addr`=0x1234 in cycle 1, `a_ack` in cycle 3. Then a read of 0x1234 → `a_ack` with `a_rdata`=0x5A exactly 3 cycles after `req` is sampled.
- **Simultaneous requests after reset.** `a_req` and `b_req` both high in the same cycle, reads of 0x0010 and 0x0020 → A served first (`a_ack` at cycle 3), B granted in cycle 3 with `b_ack` at cycle 6. Neither ack is issued twice per request.
- **Fairness.** Both ports hold `req` high for 6 transactions → ack order A,B,A,B,A,B; every ack is 3 cycles apart.
- **Reset during write.** `b_req` write of 0xFF to 0x0001 with `res` high in the MEM cycle → `ram_save` stays 0, no `b_ack`, and a later read of 0x0001 returns the old value.
- **Held request no double-grant.** `a_req` held high through `a_ack` with `b_req`=0 → second grant starts in cycle 4, not 3; exactly one ack per grant.
